// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT front end.
package fft_pkg;

  typedef enum logic [0:0] {
    CONFIG = 1'b0,
    RUN    = 1'b1
  } framer_state_t;

  localparam int unsigned FWD_INV_BIT       = 0;
  localparam logic [15:0] DEFAULT_CFG_WORD  = 16'(1) << FWD_INV_BIT;
  localparam int unsigned DEFAULT_COMP_W    = 16;
  localparam int unsigned DEFAULT_FRAME_LEN = 4096;

endpackage

// File: rtl/fft_sample_fifo.sv
// Synchronous show-ahead FIFO: rdata shows the head entry whenever not empty (0 when empty).
module fft_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fft_framer.sv
// AXI-Stream framer feeding the FFT core: one-shot config, sample FIFO, tlast framing.
// Optional drop counter enabled by defining FFT_FRAMER_DROP_CNT_EN.
module fft_framer
  import fft_pkg::*;
#(
  parameter int unsigned       SAMPLE_W   = 8,
  parameter int unsigned       COMP_W     = DEFAULT_COMP_W,
  parameter int unsigned       FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter int unsigned       CFG_W      = 16,
  parameter logic [CFG_W-1:0]  CFG_WORD   = CFG_W'(DEFAULT_CFG_WORD)
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       audio_sample_valid,
  output logic [2*COMP_W-1:0]        fft_s_tdata,
  output logic                       fft_s_tvalid,
  output logic                       fft_s_tlast,
  input  logic                       fft_s_tready,
  output logic [CFG_W-1:0]           cfg_tdata,
  output logic                       cfg_tvalid,
  input  logic                       cfg_tready,
  output logic                       overflow,
  output logic                       frame_done
`ifdef FFT_FRAMER_DROP_CNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int unsigned    CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  framer_state_t     state_q, state_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;

  logic [COMP_W-1:0] real_part;
  logic [COMP_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              sample_in_run, push, pop, drop, last;

  if (COMP_W >= SAMPLE_W) begin : g_sext
    assign real_part = COMP_W'(in_sample);
  end else begin : g_trunc
    assign real_part = in_sample[SAMPLE_W-1 -: COMP_W];
  end

  // Samples outside RUN never reach the FIFO and never count as drops.
  assign sample_in_run = audio_sample_valid && (state_q == RUN);
  assign pop           = !fifo_empty && fft_s_tready;
  assign push          = sample_in_run && (!fifo_full || pop);
  assign drop          = sample_in_run && fifo_full && !pop;
  assign last          = !fifo_empty && (cnt_q == CNT_LAST);

  fft_sample_fifo #(
    .WIDTH (COMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .push     (push),
    .wdata    (real_part),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cfg_valid_d  = cfg_valid_q;
    cnt_d        = cnt_q;
    overflow_d   = drop;
    frame_done_d = pop && last;
    unique case (state_q)
      CONFIG: begin
        cfg_valid_d = 1'b1;
        if (cfg_valid_q && cfg_tready) begin
          state_d     = RUN;
          cfg_valid_d = 1'b0;
        end
      end
      RUN: cfg_valid_d = 1'b0;
    endcase
    // FRAME_LEN is a power of two, so natural overflow is the wrap.
    if (pop) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= CONFIG;
      cfg_valid_q  <= 1'b0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_valid_q  <= cfg_valid_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef FFT_FRAMER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign fft_s_tdata  = {{COMP_W{1'b0}}, fifo_rdata};
  assign fft_s_tvalid = !fifo_empty;
  assign fft_s_tlast  = last;
  assign cfg_tdata    = CFG_WORD;
  assign cfg_tvalid   = cfg_valid_q;
  assign overflow     = overflow_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_fft_framer.sv
// Directed bench for fft_framer with FRAME_LEN = 8 and FIFO_DEPTH = 16.
module tb_fft_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_sample;
  logic        audio_sample_valid;
  logic [31:0] fft_s_tdata;
  logic        fft_s_tvalid;
  logic        fft_s_tlast;
  logic        fft_s_tready;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic        overflow;
  logic        frame_done;
`ifdef FFT_FRAMER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  fft_framer #(
    .SAMPLE_W   (8),
    .COMP_W     (16),
    .FRAME_LEN  (8),
    .FIFO_DEPTH (16),
    .CFG_W      (16),
    .CFG_WORD   (16'h0001)
  ) dut (
    .clk_in             (clk),
    .rst_in_n           (rst_n),
    .in_sample          (in_sample),
    .audio_sample_valid (audio_sample_valid),
    .fft_s_tdata        (fft_s_tdata),
    .fft_s_tvalid       (fft_s_tvalid),
    .fft_s_tlast        (fft_s_tlast),
    .fft_s_tready       (fft_s_tready),
    .cfg_tdata          (cfg_tdata),
    .cfg_tvalid         (cfg_tvalid),
    .cfg_tready         (cfg_tready),
    .overflow           (overflow),
    .frame_done         (frame_done)
`ifdef FFT_FRAMER_DROP_CNT_EN
    ,
    .drop_count         (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tdata for an 8-bit sample: imag 0, real sign-extended to 16 bits.
  function automatic logic [31:0] tdata_of(input logic [7:0] v);
    return {16'h0000, {8{v[7]}}, v};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " tvalid"},     32'(fft_s_tvalid), 32'd0);
    check_eq({tag, " tlast"},      32'(fft_s_tlast),  32'd0);
    check_eq({tag, " tdata"},      fft_s_tdata,       32'd0);
    check_eq({tag, " cfg_tvalid"}, 32'(cfg_tvalid),   32'd0);
    check_eq({tag, " cfg_tdata"},  32'(cfg_tdata),    32'h0001);
    check_eq({tag, " overflow"},   32'(overflow),     32'd0);
    check_eq({tag, " frame_done"}, 32'(frame_done),   32'd0);
`ifdef FFT_FRAMER_DROP_CNT_EN
    check_eq({tag, " drop_count"}, 32'(drop_count),   32'd0);
`endif
  endtask

  initial begin
    rst_n              = 1'b0;
    in_sample          = 8'h00;
    audio_sample_valid = 1'b0;
    fft_s_tready       = 1'b0;
    cfg_tready         = 1'b0;

    tick();
    tick();
    check_reset_outputs("rst");

    // Config held off for 5 cycles; strobes in this window must vanish.
    rst_n = 1'b1;
    check_eq("cfg_valid_before_edge", 32'(cfg_tvalid), 32'd0);
    audio_sample_valid = 1'b1;
    in_sample          = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("cfg_valid_hold%0d", i), 32'(cfg_tvalid), 32'd1);
      check_eq($sformatf("cfg_data_hold%0d", i),  32'(cfg_tdata),  32'h0001);
      check_eq($sformatf("cfg_ovf%0d", i),        32'(overflow),   32'd0);
      check_eq($sformatf("cfg_tvalid%0d", i),     32'(fft_s_tvalid), 32'd0);
    end
    cfg_tready = 1'b1;
    tick();
    check_eq("cfg_valid_drop", 32'(cfg_tvalid), 32'd0);
    check_eq("cfg_no_sample",  32'(fft_s_tvalid), 32'd0);
    check_eq("cfg_no_ovf",     32'(overflow), 32'd0);
    cfg_tready         = 1'b0;
    audio_sample_valid = 1'b0;

    // 20 back-to-back samples, first is -3; tready held high.
    fft_s_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sample          = (i == 0) ? 8'hFD : 8'(i);
      audio_sample_valid = 1'b1;
      tick();
      check_eq($sformatf("str_tvalid%0d", i), 32'(fft_s_tvalid), 32'd1);
      check_eq($sformatf("str_tdata%0d", i), fft_s_tdata,
               (i == 0) ? 32'h0000_FFFD : 32'(i));
      check_eq($sformatf("str_tlast%0d", i), 32'(fft_s_tlast),
               32'((i == 7) || (i == 15)));
      check_eq($sformatf("str_fdone%0d", i), 32'(frame_done),
               32'((i == 8) || (i == 16)));
    end
    audio_sample_valid = 1'b0;
    tick();
    check_eq("str_empty", 32'(fft_s_tvalid), 32'd0);
    check_eq("str_fdone_end", 32'(frame_done), 32'd0);

    // Stall with 20 strobes: 16 stored, 4 dropped. Frame counter now at 4.
    fft_s_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_sample          = 8'h40 + 8'(i);
      audio_sample_valid = 1'b1;
      tick();
      check_eq($sformatf("stall_ovf%0d", i),    32'(overflow), 32'(i >= 16));
      check_eq($sformatf("stall_tdata%0d", i),  fft_s_tdata, 32'h0000_0040);
      check_eq($sformatf("stall_tvalid%0d", i), 32'(fft_s_tvalid), 32'd1);
      check_eq($sformatf("stall_tlast%0d", i),  32'(fft_s_tlast), 32'd0);
    end
    audio_sample_valid = 1'b0;
    tick();
    check_eq("stall_ovf_end", 32'(overflow), 32'd0);
`ifdef FFT_FRAMER_DROP_CNT_EN
    check_eq("drop_count", 32'(drop_count), 32'd4);
`endif
    fft_s_tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check_eq($sformatf("drain_tvalid%0d", j), 32'(fft_s_tvalid), 32'd1);
      check_eq($sformatf("drain_tdata%0d", j), fft_s_tdata, tdata_of(8'h40 + 8'(j)));
      check_eq($sformatf("drain_tlast%0d", j), 32'(fft_s_tlast), 32'((j == 3) || (j == 11)));
      tick();
    end
    check_eq("drain_empty", 32'(fft_s_tvalid), 32'd0);

    // Fill to full, then strobe while popping: must be accepted without overflow.
    fft_s_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_sample          = 8'h10 + 8'(i);
      audio_sample_valid = 1'b1;
      tick();
    end
    check_eq("fill_no_ovf", 32'(overflow), 32'd0);
    fft_s_tready = 1'b1;
    in_sample    = 8'h55;
    check_eq("full_head", fft_s_tdata, 32'h0000_0010);
    tick();
    check_eq("full_pop_push_ovf", 32'(overflow), 32'd0);
    check_eq("full_pop_push_head", fft_s_tdata, 32'h0000_0011);
    audio_sample_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check_eq($sformatf("full_drain_tdata%0d", j), fft_s_tdata,
               (j < 15) ? tdata_of(8'h11 + 8'(j)) : 32'h0000_0055);
      check_eq($sformatf("full_drain_tlast%0d", j), 32'(fft_s_tlast),
               32'((j == 2) || (j == 10)));
      tick();
    end
    check_eq("full_drain_empty", 32'(fft_s_tvalid), 32'd0);
`ifdef FFT_FRAMER_DROP_CNT_EN
    check_eq("drop_count_kept", 32'(drop_count), 32'd4);
`endif

    // Counter at 5, load 3 samples, then reset between clock edges.
    fft_s_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sample          = 8'h21 + 8'(i);
      audio_sample_valid = 1'b1;
      tick();
    end
    audio_sample_valid = 1'b0;
    check_eq("pre_rst_tvalid", 32'(fft_s_tvalid), 32'd1);
    check_eq("pre_rst_tdata", fft_s_tdata, 32'h0000_0021);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    rst_n      = 1'b1;
    cfg_tready = 1'b1;
    tick();
    check_eq("recfg_valid", 32'(cfg_tvalid), 32'd1);
    check_eq("recfg_data",  32'(cfg_tdata),  32'h0001);
    tick();
    check_eq("recfg_done",    32'(cfg_tvalid), 32'd0);
    check_eq("recfg_flushed", 32'(fft_s_tvalid), 32'd0);
    cfg_tready   = 1'b0;
    fft_s_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_sample          = 8'(k + 1);
      audio_sample_valid = 1'b1;
      tick();
      check_eq($sformatf("post_tdata%0d", k), fft_s_tdata, 32'(k + 1));
      check_eq($sformatf("post_tlast%0d", k), 32'(fft_s_tlast), 32'(k == 7));
    end
    audio_sample_valid = 1'b0;
    tick();
    check_eq("post_fdone", 32'(frame_done), 32'd1);
    check_eq("post_empty", 32'(fft_s_tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
